pool_ctrl: RTL and testbench

POOL_CTRL -- requirements
Module: pool_ctrl

---
 rtl/pool_pkg.sv | 15 +
 rtl/pool_line_buf.sv | 37 +++
 rtl/pool_ctrl.sv | 217 +++++++++++++++++++++
 tb/tb_pool_ctrl.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pool_pkg.sv
// Shared types and default sizing for the 2x2 pooling controller.
package pool_pkg;

    localparam int unsigned POOL_DATA_W = 32;
    localparam int unsigned POOL_MAX_W  = 64;
    localparam int unsigned POOL_DIM_W  = 7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } pool_state_e;

endpackage

// File: rtl/pool_line_buf.sv
// Single-row line buffer: one write port, one registered read port (RAM-inferable).
module pool_line_buf #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 64,
    parameter int unsigned AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [AW-1:0]     raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
    end

    // Read register only updates on a read, so it holds the last fetched pixel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/pool_ctrl.sv
// 2x2 pooling frame controller: buffers even rows, pairs pixels for pool_kernel.
// Optional stall_cnt output enabled by defining POOL_CTRL_PERF_EN.
module pool_ctrl
    import pool_pkg::*;
#(
    parameter int unsigned DATA_W = POOL_DATA_W,
    parameter int unsigned MAX_W  = POOL_MAX_W,
    parameter int unsigned DIM_W  = POOL_DIM_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DIM_W-1:0]  cfg_width,
    input  logic [DIM_W-1:0]  cfg_height,
    output logic              busy,
    output logic              done,
    output logic              cfg_err,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [DATA_W-1:0] k_d_in1,
    output logic [DATA_W-1:0] k_d_in2,
    output logic              k_in_valid,
    input  logic [DATA_W-1:0] k_d_out,
    input  logic              k_out_valid,
    output logic [DATA_W-1:0] m_data,
`ifdef POOL_CTRL_PERF_EN
    output logic              m_valid,
    output logic [31:0]       stall_cnt
`else
    output logic              m_valid
`endif
);

    localparam int unsigned AW    = (MAX_W > 1) ? $clog2(MAX_W) : 1;
    localparam int unsigned CNT_W = 2 * DIM_W;

    pool_state_e       state_q, state_d;
    logic [DIM_W-1:0]  width_q, width_d;
    logic [DIM_W-1:0]  height_q, height_d;
    logic [DIM_W-1:0]  col_q, col_d;
    logic [DIM_W-1:0]  row_q, row_d;
    logic [CNT_W-1:0]  out_cnt_q, out_cnt_d;
    logic              cfg_err_q, cfg_err_d;
    logic              kv_q, kv_d;
    logic [DATA_W-1:0] kd2_q, kd2_d;
    logic              mv_q, mv_d;
    logic [DATA_W-1:0] md_q, md_d;
`ifdef POOL_CTRL_PERF_EN
    logic [31:0]       stall_q, stall_d;
`endif

    logic              cfg_ok;
    logic              accept;
    logic              odd_row;
    logic              last_col;
    logic              last_px;
    logic              fwd;
    logic [CNT_W-1:0]  total;
    logic [DATA_W-1:0] lb_rdata;

    assign cfg_ok = !cfg_width[0] && !cfg_height[0]
                  && (cfg_width  >= DIM_W'(2))
                  && (cfg_height >= DIM_W'(2))
                  && (32'(cfg_width) <= MAX_W);

    assign accept   = s_valid && (state_q == ST_RUN);
    assign odd_row  = row_q[0];
    assign last_col = (col_q == width_q - DIM_W'(1));
    assign last_px  = last_col && (row_q == height_q - DIM_W'(1));
    assign total    = CNT_W'(width_q >> 1) * CNT_W'(height_q >> 1);
    // Results past the expected count, or outside an active frame, are dropped.
    assign fwd      = k_out_valid
                    && ((state_q == ST_RUN) || (state_q == ST_DRAIN))
                    && (out_cnt_q != total);

    pool_line_buf #(
        .DATA_W (DATA_W),
        .DEPTH  (MAX_W),
        .AW     (AW)
    ) u_line_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (accept && !odd_row),
        .waddr_i (AW'(col_q)),
        .wdata_i (s_data),
        .re_i    (accept && odd_row),
        .raddr_i (AW'(col_q)),
        .rdata_o (lb_rdata)
    );

    always_comb begin
        state_d   = state_q;
        width_d   = width_q;
        height_d  = height_q;
        col_d     = col_q;
        row_d     = row_q;
        out_cnt_d = out_cnt_q;
        cfg_err_d = 1'b0;
        kv_d      = 1'b0;
        kd2_d     = kd2_q;
        mv_d      = 1'b0;
        md_d      = md_q;
`ifdef POOL_CTRL_PERF_EN
        stall_d   = stall_q;
`endif

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (cfg_ok) begin
                        width_d   = cfg_width;
                        height_d  = cfg_height;
                        col_d     = '0;
                        row_d     = '0;
                        out_cnt_d = '0;
`ifdef POOL_CTRL_PERF_EN
                        stall_d   = '0;
`endif
                        state_d   = ST_RUN;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (accept) begin
                    if (last_col) begin
                        col_d = '0;
                        row_d = row_q + DIM_W'(1);
                    end else begin
                        col_d = col_q + DIM_W'(1);
                    end
                    if (last_px) begin
                        state_d = ST_DRAIN;
                    end
                end
`ifdef POOL_CTRL_PERF_EN
                if (!s_valid) begin
                    stall_d = stall_q + 32'd1;
                end
`endif
            end
            ST_DRAIN: begin
                if (out_cnt_q == total) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Lower-row pixel is delayed one cycle to line up with the buffer read.
        if (accept && odd_row) begin
            kv_d  = 1'b1;
            kd2_d = s_data;
        end

        if (fwd) begin
            mv_d      = 1'b1;
            md_d      = k_d_out;
            out_cnt_d = out_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            width_q   <= '0;
            height_q  <= '0;
            col_q     <= '0;
            row_q     <= '0;
            out_cnt_q <= '0;
            cfg_err_q <= 1'b0;
            kv_q      <= 1'b0;
            kd2_q     <= '0;
            mv_q      <= 1'b0;
            md_q      <= '0;
`ifdef POOL_CTRL_PERF_EN
            stall_q   <= '0;
`endif
        end else begin
            state_q   <= state_d;
            width_q   <= width_d;
            height_q  <= height_d;
            col_q     <= col_d;
            row_q     <= row_d;
            out_cnt_q <= out_cnt_d;
            cfg_err_q <= cfg_err_d;
            kv_q      <= kv_d;
            kd2_q     <= kd2_d;
            mv_q      <= mv_d;
            md_q      <= md_d;
`ifdef POOL_CTRL_PERF_EN
            stall_q   <= stall_d;
`endif
        end
    end

    assign s_ready    = (state_q == ST_RUN);
    assign busy       = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign done       = (state_q == ST_DONE);
    assign cfg_err    = cfg_err_q;
    assign k_in_valid = kv_q;
    assign k_d_in1    = lb_rdata;
    assign k_d_in2    = kd2_q;
    assign m_valid    = mv_q;
    assign m_data     = md_q;
`ifdef POOL_CTRL_PERF_EN
    assign stall_cnt  = stall_q;
`endif

endmodule

// File: tb/tb_pool_ctrl.sv
// Directed bench for pool_ctrl with a behavioural 2x2 max-pool kernel attached.
module tb_pool_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [6:0]  cfg_width, cfg_height;
    logic        busy, done, cfg_err;
    logic [31:0] s_data;
    logic        s_valid, s_ready;
    logic [31:0] k_d_in1, k_d_in2;
    logic        k_in_valid;
    logic [31:0] k_d_out;
    logic        k_out_valid;
    logic [31:0] m_data;
    logic        m_valid;
`ifdef POOL_CTRL_PERF_EN
    logic [31:0] stall_cnt;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cnt = 0, done_cyc = 0, m_cyc = 0, err_cnt = 0;
    logic [31:0] mq[$];
    logic [31:0] k1q[$];
    logic [31:0] k2q[$];

    pool_ctrl #(.DATA_W(32), .MAX_W(64), .DIM_W(7)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .cfg_width   (cfg_width),
        .cfg_height  (cfg_height),
        .busy        (busy),
        .done        (done),
        .cfg_err     (cfg_err),
        .s_data      (s_data),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .k_d_in1     (k_d_in1),
        .k_d_in2     (k_d_in2),
        .k_in_valid  (k_in_valid),
        .k_d_out     (k_d_out),
        .k_out_valid (k_out_valid),
        .m_data      (m_data),
`ifdef POOL_CTRL_PERF_EN
        .m_valid     (m_valid),
        .stall_cnt   (stall_cnt)
`else
        .m_valid     (m_valid)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic logic [31:0] mx(input logic [31:0] a, input logic [31:0] b);
        return (a > b) ? a : b;
    endfunction

    // Kernel: max over two consecutive beats of (upper, lower) pairs.
    logic        ph;
    logic [31:0] acc;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ph <= 1'b0; acc <= '0; k_d_out <= '0; k_out_valid <= 1'b0;
        end else begin
            k_out_valid <= 1'b0;
            if (k_in_valid) begin
                if (!ph) begin
                    acc <= mx(k_d_in1, k_d_in2);
                    ph  <= 1'b1;
                end else begin
                    k_d_out     <= mx(acc, mx(k_d_in1, k_d_in2));
                    k_out_valid <= 1'b1;
                    ph          <= 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin mq.push_back(m_data); m_cyc = cyc; end
        if (k_in_valid) begin k1q.push_back(k_d_in1); k2q.push_back(k_d_in2); end
        if (done) begin done_cnt++; done_cyc = cyc; end
        if (cfg_err) err_cnt++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_q();
        mq.delete(); k1q.delete(); k2q.delete();
    endtask

    task automatic do_start(input int w, input int h);
        cfg_width = 7'(w); cfg_height = 7'(h); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic push(input logic [31:0] v);
        int n = 0;
        s_data = v; s_valid = 1'b1;
        @(negedge clk);
        while (!s_ready && n < 20) begin @(negedge clk); n++; end
        chk("push_ready", {63'd0, s_ready}, 64'd1);
        @(posedge clk); #1;
        s_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int base);
        int n = 0;
        while (done_cnt == base && n < 300) begin @(negedge clk); n++; end
        chk(tag, {63'd0, done_cnt == base + 1}, 64'd1);
    endtask

    function automatic logic [63:0] outs();
        return {busy, done, cfg_err, s_ready, k_in_valid, m_valid, k_d_in1, k_d_in2[15:0]} | 64'(m_data != 0);
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        rst_n = 1'b0; start = 1'b0; cfg_width = '0; cfg_height = '0;
        s_data = '0; s_valid = 1'b0;
        #3;
        chk("reset_outputs", outs(), 64'd0);
        chk("reset_kd2", 64'(k_d_in2), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // 4x2 continuous frame
        clear_q(); base = done_cnt;
        do_start(4, 2);
        chk("busy_run", {63'd0, busy}, 64'd1);
        for (int i = 1; i <= 8; i++) push(32'(i));
        wait_done("done_4x2", base);
        chk("kpair_count", 64'(k1q.size()), 64'd4);
        for (int i = 0; i < 4 && i < k1q.size(); i++) begin
            chk("kpair_upper", 64'(k1q[i]), 64'(i + 1));
            chk("kpair_lower", 64'(k2q[i]), 64'(i + 5));
        end
        chk("out_count_4x2", 64'(mq.size()), 64'd2);
        if (mq.size() == 2) begin
            chk("out0_4x2", 64'(mq[0]), 64'd6);
            chk("out1_4x2", 64'(mq[1]), 64'd8);
        end
        chk("done_after_last_m", 64'(done_cyc), 64'(m_cyc + 1));
        @(posedge clk); #1;
        chk("done_one_cycle", {63'd0, done}, 64'd0);
        chk("idle_busy", {62'd0, busy, s_ready}, 64'd0);
        chk("kd_hold", {k_d_in1, k_d_in2}, {32'd4, 32'd8});

        // 4x4 frame with s_valid toggling
        clear_q(); base = done_cnt;
        do_start(4, 4);
        for (int i = 1; i <= 16; i++) begin
            push(32'(i));
            if (i < 16) begin @(posedge clk); #1; end
        end
        wait_done("done_4x4", base);
        chk("out_count_4x4", 64'(mq.size()), 64'd4);
        if (mq.size() == 4) begin
            chk("out0_4x4", 64'(mq[0]), 64'd6);
            chk("out1_4x4", 64'(mq[1]), 64'd8);
            chk("out2_4x4", 64'(mq[2]), 64'd14);
            chk("out3_4x4", 64'(mq[3]), 64'd16);
        end
`ifdef POOL_CTRL_PERF_EN
        chk("stall_cnt", 64'(stall_cnt), 64'd15);
        repeat (3) @(posedge clk); #1;
        chk("stall_hold", 64'(stall_cnt), 64'd15);
`endif

        // bad configurations
        base = err_cnt;
        do_start(3, 2);
        chk("cfg_err_pulse", {61'd0, cfg_err, busy, s_ready}, 64'b100);
        @(posedge clk); #1;
        chk("cfg_err_clear", {61'd0, cfg_err, busy, s_ready}, 64'b000);
        do_start(66, 2);
        chk("cfg_err_too_wide", {61'd0, cfg_err, busy, s_ready}, 64'b100);
        @(posedge clk); #1;
        chk("cfg_err_count", 64'(err_cnt - base), 64'd2);

        // reset mid-frame then a clean 4x2 frame
        base = done_cnt;
        do_start(4, 4);
        for (int i = 1; i <= 6; i++) push(32'(i));
        chk("pre_reset_kd", {k_d_in1, k_d_in2}, {32'd2, 32'd6});
        rst_n = 1'b0;
        #1;
        chk("abort_outputs", outs(), 64'd0);
        chk("abort_kd2", 64'(k_d_in2), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk); #1;
        chk("abort_no_done", 64'(done_cnt), 64'(base));
        clear_q();
        do_start(4, 2);
        for (int i = 1; i <= 8; i++) push(32'(i));
        wait_done("done_after_abort", base);
        chk("out_count_abort", 64'(mq.size()), 64'd2);
        if (mq.size() == 2) begin
            chk("out0_abort", 64'(mq[0]), 64'd6);
            chk("out1_abort", 64'(mq[1]), 64'd8);
        end

        // start during RUN is ignored
        clear_q(); base = done_cnt;
        do_start(4, 2);
        for (int i = 1; i <= 3; i++) push(32'(i));
        do_start(2, 2);
        chk("restart_ignored", {61'd0, busy, s_ready, cfg_err}, 64'b110);
        cfg_width = 7'd4; cfg_height = 7'd2;
        for (int i = 4; i <= 8; i++) push(32'(i));
        wait_done("done_restart", base);
        chk("out_count_restart", 64'(mq.size()), 64'd2);
        if (mq.size() == 2) begin
            chk("out0_restart", 64'(mq[0]), 64'd6);
            chk("out1_restart", 64'(mq[1]), 64'd8);
        end

        // maximum width 64x2 ramp
        clear_q(); base = done_cnt;
        do_start(64, 2);
        for (int i = 0; i < 128; i++) push(32'(i));
        wait_done("done_64x2", base);
        chk("out_count_64", 64'(mq.size()), 64'd32);
        for (int i = 0; i < 32 && i < mq.size(); i++) begin
            chk("out_64", 64'(mq[i]), 64'(65 + 2 * i));
        end

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
